// File: rtl/lfsr_pkg.sv
// Shared definitions for the lfsr_gen block.
//  - fsm_e        : burst controller states
//  - default_taps : maximal-length feedback masks for widths 3..32
//  - lfsr_next    : one Fibonacci step (shift left, XOR of tapped bits enters bit 0)
package lfsr_pkg;

  typedef enum logic {StIdle, StBurst} fsm_e;

  localparam int unsigned MaxWidth = 32;

  // Bit i set => state[i] feeds the XOR. Polynomial x^n + x^k + ... maps to bits n-1, k-1, ...
  function automatic logic [31:0] default_taps(input int unsigned width);
    logic [31:0] taps;
    case (width)
      3:       taps = 32'h0000_0006;
      4:       taps = 32'h0000_000C;
      5:       taps = 32'h0000_0014;
      6:       taps = 32'h0000_0030;
      7:       taps = 32'h0000_0060;
      8:       taps = 32'h0000_00B8;
      9:       taps = 32'h0000_0110;
      10:      taps = 32'h0000_0240;
      11:      taps = 32'h0000_0500;
      12:      taps = 32'h0000_0829;
      13:      taps = 32'h0000_100D;
      14:      taps = 32'h0000_2015;
      15:      taps = 32'h0000_6000;
      16:      taps = 32'h0000_D008;
      17:      taps = 32'h0001_2000;
      18:      taps = 32'h0002_0400;
      19:      taps = 32'h0004_0023;
      20:      taps = 32'h0009_0000;
      21:      taps = 32'h0014_0000;
      22:      taps = 32'h0030_0000;
      23:      taps = 32'h0042_0000;
      24:      taps = 32'h00E1_0000;
      25:      taps = 32'h0120_0000;
      26:      taps = 32'h0200_0023;
      27:      taps = 32'h0400_0013;
      28:      taps = 32'h0900_0000;
      29:      taps = 32'h1400_0000;
      30:      taps = 32'h2000_0029;
      31:      taps = 32'h4800_0000;
      32:      taps = 32'h8020_0003;
      default: taps = 32'h0000_0000;
    endcase
    return taps;
  endfunction

  // Result is masked to the active width; callers truncate to their own state width.
  function automatic logic [31:0] lfsr_next(input logic [31:0] state, input logic [31:0] taps,
                                            input int unsigned width);
    logic [31:0] mask;
    mask = (width >= MaxWidth) ? '1 : ((32'd1 << width) - 32'd1);
    return ((state << 1) | {31'd0, ^(state & taps)}) & mask;
  endfunction

endpackage

// File: rtl/lfsr_gen_if.sv
// Control/status bundle of lfsr_gen.
//  master: drives load/seed_i/run/start/len_i, observes the status outputs.
//  slave : the generator itself.
interface lfsr_gen_if #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned CNT_W = 8
);
  logic             load;
  logic [WIDTH-1:0] seed_i;
  logic             run;
  logic             start;
  logic [CNT_W-1:0] len_i;
  logic [WIDTH-1:0] lfsr_o;
  logic             bit_o;
  logic             busy;
  logic             done;
  logic             wrap_o;
  logic             lockup_o;

  modport master (
    output load, seed_i, run, start, len_i,
    input  lfsr_o, bit_o, busy, done, wrap_o, lockup_o
  );

  modport slave (
    input  load, seed_i, run, start, len_i,
    output lfsr_o, bit_o, busy, done, wrap_o, lockup_o
  );
endinterface

// File: rtl/lfsr_core.sv
// LFSR state register with next-state XOR and optional lock-up recovery.
// Build option: LFSR_LOCKUP_RECOVER_EN -- a step from all-zero loads SEED and pulses lockup_o.
// Ports:
//  clk, reset  clock, async active-low reset
//  load_i      load load_val_i (wins over step_i)
//  load_val_i  value to load
//  step_i      advance one step
//  state_o     current state
//  next_o      state that a step would produce
//  lockup_o    registered pulse, one cycle after a recovery step
module lfsr_core import lfsr_pkg::*; #(
  parameter int unsigned      WIDTH = 4,
  parameter logic [WIDTH-1:0] TAPS  = 4'b1100,
  parameter logic [WIDTH-1:0] SEED  = 4'b1010
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  input  logic             step_i,
  output logic [WIDTH-1:0] state_o,
  output logic [WIDTH-1:0] next_o,
  output logic             lockup_o
);

  logic [WIDTH-1:0] state_q, state_d, step_val;
  logic             lockup_q, lockup_d;

  always_comb begin
    step_val = WIDTH'(lfsr_next(32'(state_q), 32'(TAPS), WIDTH));
    lockup_d = 1'b0;
`ifdef LFSR_LOCKUP_RECOVER_EN
    if (state_q == '0) begin
      step_val = SEED;
      lockup_d = step_i && !load_i;
    end
`endif
    state_d = state_q;
    if (load_i) begin
      state_d = load_val_i;
    end else if (step_i) begin
      state_d = step_val;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= SEED;
      lockup_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      lockup_q <= lockup_d;
    end
  end

  assign state_o  = state_q;
  assign next_o   = step_val;
  assign lockup_o = lockup_q;

endmodule

// File: rtl/lfsr_gen.sv
// Parametrised Fibonacci LFSR pattern generator with seed load, free-run, counted bursts
// and period-wrap detection.
// Build option: LFSR_LOCKUP_RECOVER_EN enables all-zero lock-up recovery (else lockup_o = 0).
// Ports:
//  clk    clock, rising edge
//  reset  asynchronous active-low reset
//  bus    lfsr_gen_if slave: load/seed_i/run/start/len_i in;
//         lfsr_o/bit_o/busy/done/wrap_o/lockup_o out (all registered)
module lfsr_gen import lfsr_pkg::*; #(
  parameter int unsigned      WIDTH = 4,
  parameter logic [WIDTH-1:0] TAPS  = 4'b1100,
  parameter logic [WIDTH-1:0] SEED  = 4'b1010,
  parameter int unsigned      CNT_W = 8
) (
  input  logic       clk,
  input  logic       reset,
  lfsr_gen_if.slave  bus
);

  fsm_e             fsm_q, fsm_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] seed_q, seed_d;
  logic [WIDTH-1:0] state, next_val;
  logic             step;
  logic             done_q, done_d;
  logic             wrap_q, wrap_d;
  logic             lockup;

  lfsr_core #(
    .WIDTH (WIDTH),
    .TAPS  (TAPS),
    .SEED  (SEED)
  ) u_core (
    .clk        (clk),
    .reset      (reset),
    .load_i     (bus.load),
    .load_val_i (bus.seed_i),
    .step_i     (step),
    .state_o    (state),
    .next_o     (next_val),
    .lockup_o   (lockup)
  );

  // cnt holds the steps still owed after the current cycle's step; the start edge already
  // performs the first step, so a burst of len_i is len_i steps in total.
  always_comb begin
    fsm_d  = fsm_q;
    cnt_d  = cnt_q;
    seed_d = seed_q;
    step   = 1'b0;
    done_d = 1'b0;
    if (bus.load) begin
      fsm_d  = StIdle;
      cnt_d  = '0;
      seed_d = bus.seed_i;
    end else begin
      unique case (fsm_q)
        StIdle: begin
          if (bus.start) begin
            if (bus.len_i == '0) begin
              done_d = 1'b1;
            end else begin
              step  = 1'b1;
              cnt_d = bus.len_i - CNT_W'(1);
              if (bus.len_i == CNT_W'(1)) begin
                done_d = 1'b1;
              end else begin
                fsm_d = StBurst;
              end
            end
          end else if (bus.run) begin
            step = 1'b1;
          end
        end
        StBurst: begin
          step  = 1'b1;
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            fsm_d  = StIdle;
            done_d = 1'b1;
          end
        end
      endcase
    end
    wrap_d = step && (next_val == seed_q);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fsm_q  <= StIdle;
      cnt_q  <= '0;
      seed_q <= SEED;
      done_q <= 1'b0;
      wrap_q <= 1'b0;
    end else begin
      fsm_q  <= fsm_d;
      cnt_q  <= cnt_d;
      seed_q <= seed_d;
      done_q <= done_d;
      wrap_q <= wrap_d;
    end
  end

  assign bus.lfsr_o   = state;
  assign bus.bit_o    = state[WIDTH-1];
  assign bus.busy     = (fsm_q == StBurst);
  assign bus.done     = done_q;
  assign bus.wrap_o   = wrap_q;
  assign bus.lockup_o = lockup;

endmodule

// File: tb/tb_lfsr_gen.sv
// Self-checking bench for lfsr_gen (WIDTH=4 defaults): directed scenarios plus randomized
// traffic against a cycle-level reference model.
module tb_lfsr_gen;

  localparam int unsigned W    = 4;
  localparam int unsigned CW   = 8;
  localparam logic [3:0]  TAPS = 4'b1100;
  localparam logic [3:0]  SEED = 4'b1010;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  lfsr_gen_if #(.WIDTH(W), .CNT_W(CW)) bus ();

  lfsr_gen #(
    .WIDTH (W),
    .TAPS  (TAPS),
    .SEED  (SEED),
    .CNT_W (CW)
  ) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: state, seed, steps still owed in the current burst, pending pulses.
  logic [3:0] m_state, m_seed;
  int         m_left;
  logic       m_done, m_wrap, m_lock;

  int n_wrap, n_done, n_busy, n_lock;
  bit seen[16];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [3:0] ref_step(input logic [3:0] s);
`ifdef LFSR_LOCKUP_RECOVER_EN
    if (s == 4'd0) return SEED;
`endif
    return 4'((int'(s) * 2 + ($countones(s & TAPS) % 2)) % 16);
  endfunction

  task automatic model_reset();
    m_state = SEED;
    m_seed  = SEED;
    m_left  = 0;
    m_done  = 1'b0;
    m_wrap  = 1'b0;
    m_lock  = 1'b0;
  endtask

  task automatic model_edge(input logic ld, input logic [3:0] sd, input logic rn,
                            input logic st, input logic [7:0] ln);
    logic       do_step;
    logic [3:0] nxt;
    do_step = 1'b0;
    m_done  = 1'b0;
    m_wrap  = 1'b0;
    m_lock  = 1'b0;
    if (ld) begin
      m_state = sd;
      m_seed  = sd;
      m_left  = 0;
    end else if (m_left > 0) begin
      do_step = 1'b1;
      m_left--;
      if (m_left == 0) m_done = 1'b1;
    end else if (st) begin
      if (ln == 8'd0) begin
        m_done = 1'b1;
      end else begin
        do_step = 1'b1;
        m_left  = int'(ln) - 1;
        if (m_left == 0) m_done = 1'b1;
      end
    end else if (rn) begin
      do_step = 1'b1;
    end
    if (do_step) begin
      nxt = ref_step(m_state);
      m_wrap = (nxt == m_seed);
`ifdef LFSR_LOCKUP_RECOVER_EN
      m_lock = (m_state == 4'd0);
`endif
      m_state = nxt;
    end
  endtask

  task automatic check_outputs();
    check_eq("lfsr", bus.lfsr_o, m_state);
    check_eq("bit", bus.bit_o, m_state[3]);
    check_eq("busy", bus.busy, (m_left > 0));
    check_eq("done", bus.done, m_done);
    check_eq("wrap", bus.wrap_o, m_wrap);
    check_eq("lock", bus.lockup_o, m_lock);
  endtask

  task automatic clear_counts();
    n_wrap = 0;
    n_done = 0;
    n_busy = 0;
    n_lock = 0;
    for (int i = 0; i < 16; i++) seen[i] = 1'b0;
  endtask

  // One clock: drive inputs, advance model on the edge, sample 1 ns later.
  task automatic cyc(input logic ld, input logic [3:0] sd, input logic rn, input logic st,
                     input logic [7:0] ln);
    bus.load   = ld;
    bus.seed_i = sd;
    bus.run    = rn;
    bus.start  = st;
    bus.len_i  = ln;
    @(posedge clk);
    model_edge(ld, sd, rn, st, ln);
    #1;
    check_outputs();
    n_wrap += int'(bus.wrap_o);
    n_done += int'(bus.done);
    n_busy += int'(bus.busy);
    n_lock += int'(bus.lockup_o);
    seen[bus.lfsr_o] = 1'b1;
  endtask

  task automatic idle();
    cyc(1'b0, 4'd0, 1'b0, 1'b0, 8'd0);
  endtask

  task automatic run1();
    cyc(1'b0, 4'd0, 1'b1, 1'b0, 8'd0);
  endtask

  logic [3:0] exp1 [4];
  int         n_seen;

  initial begin
    exp1 = '{4'h5, 4'hB, 4'h7, 4'hF};
    reset      = 1'b0;
    bus.load   = 1'b0;
    bus.seed_i = '0;
    bus.run    = 1'b0;
    bus.start  = 1'b0;
    bus.len_i  = '0;
    model_reset();
    clear_counts();

    // 1. Reset values, then first four free-run steps.
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_lfsr", bus.lfsr_o, 4'b1010);
    check_eq("rst_busy", bus.busy, 1'b0);
    check_eq("rst_done", bus.done, 1'b0);
    check_eq("rst_wrap", bus.wrap_o, 1'b0);
    check_eq("rst_lock", bus.lockup_o, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      run1();
      check_eq("t1_seq", bus.lfsr_o, exp1[i]);
    end

    // 2. Full period from 1010: one wrap, all 15 non-zero states.
    cyc(1'b1, 4'b1010, 1'b0, 1'b0, 8'd0);
    clear_counts();
    repeat (15) run1();
    n_seen = 0;
    for (int i = 0; i < 16; i++) n_seen += int'(seen[i]);
    check_eq("t2_final", bus.lfsr_o, 4'b1010);
    check_eq("t2_wraps", n_wrap, 1);
    check_eq("t2_states", n_seen, 15);
    check_eq("t2_zero_seen", seen[0], 1'b0);

    // 3. Burst of 3 with start re-asserted mid-burst.
    clear_counts();
    cyc(1'b0, 4'd0, 1'b0, 1'b1, 8'd3);
    cyc(1'b0, 4'd0, 1'b0, 1'b1, 8'd5);
    idle();
    check_eq("t3_final", bus.lfsr_o, 4'b0111);
    idle();
    check_eq("t3_dones", n_done, 1);
    check_eq("t3_busy_cycles", n_busy, 2);
    check_eq("t3_hold", bus.lfsr_o, 4'b0111);

    // 4. Zero-length burst: done only.
    cyc(1'b0, 4'd0, 1'b0, 1'b1, 8'd0);
    check_eq("t4_lfsr", bus.lfsr_o, 4'b0111);
    check_eq("t4_busy", bus.busy, 1'b0);
    check_eq("t4_done", bus.done, 1'b1);
    idle();
    check_eq("t4_done_clr", bus.done, 1'b0);

    // 5. Load aborts a burst without done; new seed sets the wrap point.
    clear_counts();
    cyc(1'b0, 4'd0, 1'b0, 1'b1, 8'd10);
    idle();
    idle();
    cyc(1'b1, 4'b0011, 1'b0, 1'b0, 8'd0);
    check_eq("t5_lfsr", bus.lfsr_o, 4'b0011);
    check_eq("t5_busy", bus.busy, 1'b0);
    repeat (3) idle();
    check_eq("t5_no_done", n_done, 0);
    clear_counts();
    repeat (15) run1();
    check_eq("t5_final", bus.lfsr_o, 4'b0011);
    check_eq("t5_wraps", n_wrap, 1);
    check_eq("t5_wrap_now", bus.wrap_o, 1'b1);

    // 6. All-zero load.
    clear_counts();
    cyc(1'b1, 4'b0000, 1'b0, 1'b0, 8'd0);
    check_eq("t6_loaded", bus.lfsr_o, 4'b0000);
    run1();
`ifdef LFSR_LOCKUP_RECOVER_EN
    check_eq("t6_recover", bus.lfsr_o, 4'b1010);
    check_eq("t6_lock_pulse", bus.lockup_o, 1'b1);
    repeat (3) run1();
    check_eq("t6_lock_count", n_lock, 1);
`else
    check_eq("t6_stuck", bus.lfsr_o, 4'b0000);
    repeat (3) run1();
    check_eq("t6_still_stuck", bus.lfsr_o, 4'b0000);
    check_eq("t6_lock_count", n_lock, 0);
`endif

    // 7. Randomized traffic against the model.
    for (int i = 0; i < 600; i++) begin
      cyc(($urandom_range(0, 19) == 0), 4'($urandom), 1'($urandom_range(0, 1)),
          ($urandom_range(0, 5) == 0), 8'($urandom_range(0, 6)));
    end

    // 8. Reset in the middle of a burst: immediate reset values, no done afterwards.
    cyc(1'b1, 4'b0110, 1'b0, 1'b0, 8'd0);
    cyc(1'b0, 4'd0, 1'b0, 1'b1, 8'd8);
    idle();
    check_eq("t8_busy_before", bus.busy, 1'b1);
    #2;
    reset = 1'b0;
    #1;
    model_reset();
    check_eq("t8_rst_lfsr", bus.lfsr_o, 4'b1010);
    check_eq("t8_rst_busy", bus.busy, 1'b0);
    check_eq("t8_rst_done", bus.done, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    clear_counts();
    repeat (4) idle();
    check_eq("t8_no_done", n_done, 0);
    check_eq("t8_hold", bus.lfsr_o, 4'b1010);
    repeat (16) run1();
    check_eq("t8_seed_reset", n_wrap, 1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
